// File: rtl/iir_fold3_pkg.sv
// Shared widths, phase encoding and output rounding/saturation
// for the 3-folded IIR multiply-accumulate stage.
package iir_fold3_pkg;

  localparam int DW   = 20;
  localparam int PW   = 40;
  localparam int ACCW = 42;

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;

  typedef enum logic {ST_IDLE, ST_RUN} fold_state_t;

  localparam logic signed [ACCW-1:0] SAT_MAX = 42'sd524287;
  localparam logic signed [ACCW-1:0] SAT_MIN = -42'sd524288;

  // Round half up at bit frac, then clamp into the DW-bit signed range.
  function automatic logic signed [DW-1:0] sat_round(input logic signed [ACCW-1:0] a,
                                                     input int frac);
    logic signed [ACCW-1:0] rnd;
    logic signed [ACCW-1:0] shf;
    rnd = a + (ACCW'(1) << (frac - 1));
    shf = rnd >>> frac;
    if (shf > SAT_MAX)
      shf = SAT_MAX;
    else if (shf < SAT_MIN)
      shf = SAT_MIN;
    return shf[DW-1:0];
  endfunction

endpackage

// File: rtl/iir_fold3_mac_if.sv
// Sample/feedback/result bundle between the IIR datapath and the folded MAC.
interface iir_fold3_mac_if;
  import iir_fold3_pkg::*;

  logic signed [DW-1:0] x_in;
  logic                 x_valid;
  logic                 x_ready;
  logic signed [DW-1:0] fb_in;
  logic [1:0]           phase;
  logic signed [DW-1:0] y_out;
  logic                 y_valid;

  modport master (output x_in, x_valid, fb_in,
                  input  x_ready, phase, y_out, y_valid);

  modport slave  (input  x_in, x_valid, fb_in,
                  output x_ready, phase, y_out, y_valid);
endinterface

// File: rtl/fold3_phase_ctr.sv
// Fold sequencer: IDLE/RUN state, phase counter and sample handshake.
//   state | meaning
//   IDLE  | no fold in flight, ready for a sample (phase 0)
//   RUN   | fold in flight, phase 1 then phase 2; phase 2 may accept the next sample
module fold3_phase_ctr
  import iir_fold3_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       x_valid,
  output logic       x_ready,
  output logic       accept,
  output logic [1:0] phase
);

  fold_state_t state;

  assign x_ready = !rst && (state == ST_IDLE || phase == PH2);
  assign accept  = x_valid && x_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      phase <= PH0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_RUN;
            phase <= PH1;
          end
        end
        ST_RUN: begin
          if (phase == PH1) begin
            phase <= PH2;
          end else if (accept) begin
            phase <= PH1;
          end else begin
            state <= ST_IDLE;
            phase <= PH0;
          end
        end
        default: begin
          state <= ST_IDLE;
          phase <= PH0;
        end
      endcase
    end
  end

endmodule

// File: rtl/iir_fold3_mac.sv
// Folded MAC of the 3-folded IIR: C0*x, then C1*fb and C2*fb accumulated,
// rounded and saturated to one 20-bit result per fold.
module iir_fold3_mac
  import iir_fold3_pkg::*;
#(
  parameter logic signed [DW-1:0] C0   = 20'sd4096,
  parameter logic signed [DW-1:0] C1   = 20'sd2048,
  parameter logic signed [DW-1:0] C2   = -20'sd1024,
  parameter int                   FRAC = 12
) (
  input logic             clk,
  input logic             rst,
  iir_fold3_mac_if.slave  bus
);

  logic                   accept;
  logic                   ready;
  logic [1:0]             phase;
  logic signed [DW-1:0]   coef_fb;
  logic signed [PW-1:0]   prod_x;
  logic signed [PW-1:0]   prod_fb;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] acc_fb;
  logic signed [DW-1:0]   y_q;
  logic                   y_valid_q;

  fold3_phase_ctr u_ctr (
    .clk     (clk),
    .rst     (rst),
    .x_valid (bus.x_valid),
    .x_ready (ready),
    .accept  (accept),
    .phase   (phase)
  );

  // The x product of a new fold coincides with the previous fold's phase-2
  // term on back-to-back samples, so it is kept apart from the shared fb multiplier.
  assign coef_fb = (phase == PH2) ? C2 : C1;
  assign prod_fb = PW'(coef_fb) * PW'(bus.fb_in);
  assign prod_x  = PW'(C0) * PW'(bus.x_in);
  assign acc_fb  = acc + ACCW'(prod_fb);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      y_valid_q <= 1'b0;
      if (phase == PH2) begin
        y_q       <= sat_round(acc_fb, FRAC);
        y_valid_q <= 1'b1;
      end
      if (accept)
        acc <= ACCW'(prod_x);
      else if (phase == PH1)
        acc <= acc_fb;
    end
  end

  assign bus.x_ready = ready;
  assign bus.phase   = phase;
  assign bus.y_out   = y_q;
  assign bus.y_valid = y_valid_q;

endmodule

// File: tb/tb_iir_fold3_mac.sv
// Directed bench for iir_fold3_mac: default coefficients plus a C0=2048 copy
// fed the same stimulus.
module tb_iir_fold3_mac;
  import iir_fold3_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  iir_fold3_mac_if bus ();
  iir_fold3_mac_if bus_r ();

  assign bus_r.x_in    = bus.x_in;
  assign bus_r.x_valid = bus.x_valid;
  assign bus_r.fb_in   = bus.fb_in;

  iir_fold3_mac dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  iir_fold3_mac #(.C0(20'sd2048)) dut_r (
    .clk (clk),
    .rst (rst),
    .bus (bus_r)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated fold; the block is expected idle on entry.
  task automatic run_fold(input string tag, input int x, input int fb1, input int fb2,
                          input int exp_y, input int exp_r);
    bus.x_in    = DW'(x);
    bus.x_valid = 1'b1;
    bus.fb_in   = '0;
    #1;
    check({tag, "_rdy0"}, 32'(bus.x_ready), 1);
    tick();
    bus.x_valid = 1'b0;
    bus.fb_in   = DW'(fb1);
    check({tag, "_ph1"}, 32'(bus.phase), 1);
    check({tag, "_rdy1"}, 32'(bus.x_ready), 0);
    tick();
    bus.fb_in = DW'(fb2);
    check({tag, "_ph2"}, 32'(bus.phase), 2);
    check({tag, "_vld_early"}, 32'(bus.y_valid), 0);
    tick();
    check({tag, "_vld"}, 32'(bus.y_valid), 1);
    check({tag, "_y"}, 32'(bus.y_out), exp_y);
    check({tag, "_y_r"}, 32'(bus_r.y_out), exp_r);
    check({tag, "_ph0"}, 32'(bus.phase), 0);
    tick();
    check({tag, "_vld_pulse"}, 32'(bus.y_valid), 0);
    check({tag, "_hold"}, 32'(bus.y_out), exp_y);
  endtask

  initial begin
    bus.x_in    = '0;
    bus.x_valid = 1'b0;
    bus.fb_in   = '0;
    rst         = 1'b1;
    tick();
    tick();
    check("rst_y", 32'(bus.y_out), 0);
    check("rst_vld", 32'(bus.y_valid), 0);
    check("rst_ph", 32'(bus.phase), 0);
    check("rst_rdy", 32'(bus.x_ready), 0);
    rst = 1'b0;
    #1;
    check("rel_rdy", 32'(bus.x_ready), 1);

    run_fold("basic", 100, 40, 80, 100, 50);
    run_fold("rnd_pos", 3, 0, 0, 3, 2);
    run_fold("rnd_neg", -3, 0, 0, -3, -1);
    run_fold("sat_pos", 524287, 524287, 0, 524287, 524287);
    run_fold("sat_neg", -524288, -524288, 0, -524288, -524288);

    // Back-to-back: x_valid held high for three samples.
    bus.fb_in = '0;
    for (int k = 0; k < 3; k++) begin
      bus.x_in    = DW'(10 * (k + 1));
      bus.x_valid = 1'b1;
      tick();
      if (k > 0) begin
        check("b2b_vld", 32'(bus.y_valid), 1);
        check("b2b_y", 32'(bus.y_out), 10 * k);
        check("b2b_y_r", 32'(bus_r.y_out), 5 * k);
      end
      check("b2b_ph1", 32'(bus.phase), 1);
      check("b2b_rdy1", 32'(bus.x_ready), 0);
      if (k == 2) bus.x_valid = 1'b0;
      tick();
      check("b2b_ph2", 32'(bus.phase), 2);
      check("b2b_rdy2", 32'(bus.x_ready), 1);
      check("b2b_vld_gap", 32'(bus.y_valid), 0);
    end
    tick();
    check("b2b_vld_last", 32'(bus.y_valid), 1);
    check("b2b_y_last", 32'(bus.y_out), 30);
    check("b2b_ph_idle", 32'(bus.phase), 0);
    tick();
    check("b2b_rdy_idle", 32'(bus.x_ready), 1);

    // Stall: no samples offered after a result.
    run_fold("pre_stall", 77, 0, 0, 77, 39);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_y", 32'(bus.y_out), 77);
      check("stall_vld", 32'(bus.y_valid), 0);
      check("stall_ph", 32'(bus.phase), 0);
      check("stall_rdy", 32'(bus.x_ready), 1);
    end

    // Reset during phase 2 abandons the fold.
    bus.x_in    = DW'(100);
    bus.x_valid = 1'b1;
    tick();
    bus.x_valid = 1'b0;
    bus.fb_in   = DW'(40);
    tick();
    check("mid_ph2", 32'(bus.phase), 2);
    rst = 1'b1;
    #1;
    check("mid_rdy_rst", 32'(bus.x_ready), 0);
    tick();
    check("mid_vld", 32'(bus.y_valid), 0);
    check("mid_y", 32'(bus.y_out), 0);
    check("mid_y_r", 32'(bus_r.y_out), 0);
    check("mid_ph", 32'(bus.phase), 0);
    rst = 1'b0;
    #1;
    check("mid_rdy_rel", 32'(bus.x_ready), 1);
    tick();
    check("mid_vld_after", 32'(bus.y_valid), 0);

    run_fold("post_rst", 100, 40, 80, 100, 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
